// File: rtl/alu_secuenciador.sv
// alu_secuenciador: operator-stepped sequencer for the lab ALU.
// One switch bank and one step button load operand A, operand B and the
// operation select. The ALU result and flags are then captured and held
// for display.
// Optional build macro ALU_SECUENCIADOR_ACUM_EN: leaving MUESTRA chains the
// held result into operand A and resumes at CARGA_B.
//
// Step semantics: every clean rising edge of boton yields one pulso. A pulso
// is consumed by the state it lands in (CARGA_A/B/OP, MUESTRA). EJECUTA and
// cancelar discard it. listo is high exactly while resultado/banderas hold a
// fresh result, i.e. while estado is MUESTRA.
module alu_secuenciador #(
    parameter int ANCHO     = 4,
    parameter int ANCHO_SEL = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ANCHO-1:0]     dato_in,
    input  logic                 boton,
    input  logic                 cancelar,
    output logic [ANCHO-1:0]     op_a,
    output logic [ANCHO-1:0]     op_b,
    output logic [ANCHO_SEL-1:0] sel,
    input  logic [ANCHO-1:0]     alu_resultado,
    input  logic [3:0]           alu_banderas,
    output logic [ANCHO-1:0]     resultado,
    output logic [3:0]           banderas,
    output logic [2:0]           estado,
    output logic                 listo
);

    typedef enum logic [2:0] {
        CARGA_A  = 3'd0,
        CARGA_B  = 3'd1,
        CARGA_OP = 3'd2,
        EJECUTA  = 3'd3,
        MUESTRA  = 3'd4
    } estado_t;

    estado_t              est_q, est_d;
    logic                 s1, s2, s3;
    logic                 pulso;
    logic [ANCHO-1:0]     op_a_d, op_b_d, res_d;
    logic [ANCHO_SEL-1:0] sel_d;
    logic [3:0]           ban_d;
    logic                 listo_d;

    // Button synchronizer plus one extra flop for rising-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= boton;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A held button gives one pulse; release and re-press gives another.
    assign pulso  = s2 & ~s3;
    assign estado = est_q;

    // State and datapath registers; everything holds unless the FSM says otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            est_q     <= CARGA_A;
            op_a      <= '0;
            op_b      <= '0;
            sel       <= '0;
            resultado <= '0;
            banderas  <= '0;
            listo     <= 1'b0;
        end else begin
            est_q     <= est_d;
            op_a      <= op_a_d;
            op_b      <= op_b_d;
            sel       <= sel_d;
            resultado <= res_d;
            banderas  <= ban_d;
            listo     <= listo_d;
        end
    end

    // Next-state and load decisions; cancelar overrides any coincident pulse.
    always_comb begin
        est_d   = est_q;
        op_a_d  = op_a;
        op_b_d  = op_b;
        sel_d   = sel;
        res_d   = resultado;
        ban_d   = banderas;
        listo_d = listo;
        if (cancelar) begin
            est_d   = CARGA_A;
            listo_d = 1'b0;
        end else begin
            case (est_q)
                CARGA_A: begin
                    if (pulso) begin
                        op_a_d = dato_in;
                        est_d  = CARGA_B;
                    end
                end
                CARGA_B: begin
                    if (pulso) begin
                        op_b_d = dato_in;
                        est_d  = CARGA_OP;
                    end
                end
                CARGA_OP: begin
                    if (pulso) begin
                        sel_d = dato_in[ANCHO_SEL-1:0];
                        est_d = EJECUTA;
                    end
                end
                EJECUTA: begin
                    // ALU inputs have been stable since the previous edge.
                    res_d   = alu_resultado;
                    ban_d   = alu_banderas;
                    listo_d = 1'b1;
                    est_d   = MUESTRA;
                end
                MUESTRA: begin
                    if (pulso) begin
                        listo_d = 1'b0;
`ifdef ALU_SECUENCIADOR_ACUM_EN
                        op_a_d  = resultado;
                        est_d   = CARGA_B;
`else
                        est_d   = CARGA_A;
`endif
                    end
                end
                default: begin
                    est_d   = CARGA_A;
                    listo_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_secuenciador.sv
// tb_alu_secuenciador: directed bench for alu_secuenciador with a stub ALU,
// a step-level reference model, a result scoreboard and literal checkpoints.
// Honours ALU_SECUENCIADOR_ACUM_EN when the build defines it.
module tb_alu_secuenciador;

    localparam int W  = 4;
    localparam int WS = 3;

    logic          clock;
    logic          reset;
    logic [W-1:0]  dato_in;
    logic          boton;
    logic          cancelar;
    logic [W-1:0]  op_a, op_b, resultado, alu_resultado;
    logic [WS-1:0] sel;
    logic [3:0]    alu_banderas, banderas;
    logic [2:0]    estado;
    logic          listo;

    int n_vec = 0;
    int n_err = 0;

    alu_secuenciador #(.ANCHO(W), .ANCHO_SEL(WS)) dut (
        .clock         (clock),
        .reset         (reset),
        .dato_in       (dato_in),
        .boton         (boton),
        .cancelar      (cancelar),
        .op_a          (op_a),
        .op_b          (op_b),
        .sel           (sel),
        .alu_resultado (alu_resultado),
        .alu_banderas  (alu_banderas),
        .resultado     (resultado),
        .banderas      (banderas),
        .estado        (estado),
        .listo         (listo)
    );

    // Clock: 10 ns period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stub ALU: returns {result, N, Z, C, V}.
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        logic [4:0] t;
        logic [3:0] r;
        logic       c, v;
        t = '0;
        c = 1'b0;
        v = 1'b0;
        case (s)
            3'd0: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[3:0];
                c = t[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'd1: begin
                t = {1'b0, a} - {1'b0, b};
                r = t[3:0];
                c = t[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            default: r = a ^ b;
        endcase
        return {r, r[3], (r == 4'd0), c, v};
    endfunction

    always_comb {alu_resultado, alu_banderas} = alu_fn(op_a, op_b, sel);

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model at operator-step level.
    // hist[i] is boton as seen i+1 edges ago; a step acts two edges after the
    // first edge that sees the button up, provided the edge before saw it down.
    int         m_state;
    logic [3:0] m_a, m_b, m_res, m_ban;
    logic [2:0] m_sel;
    logic       m_listo;
    logic [2:0] hist;
    logic       m_step;
    logic [7:0] exp_q[$];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = 0;
            m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_ban = 0;
            m_listo = 1'b0;
            hist = 3'b000;
            exp_q.delete();
        end else begin
            m_step = hist[1] && !hist[2];
            if (cancelar) begin
                m_state = 0;
                m_listo = 1'b0;
            end else if (m_state == 0 && m_step) begin
                m_a = dato_in; m_state = 1;
            end else if (m_state == 1 && m_step) begin
                m_b = dato_in; m_state = 2;
            end else if (m_state == 2 && m_step) begin
                m_sel = dato_in[WS-1:0]; m_state = 3;
            end else if (m_state == 3) begin
                {m_res, m_ban} = alu_fn(m_a, m_b, m_sel);
                exp_q.push_back({m_res, m_ban});
                m_listo = 1'b1;
                m_state = 4;
            end else if (m_state == 4 && m_step) begin
                m_listo = 1'b0;
`ifdef ALU_SECUENCIADOR_ACUM_EN
                m_a = m_res;
                m_state = 1;
`else
                m_state = 0;
`endif
            end
            hist = {hist[1:0], boton};
        end
    end

    // Compare process: every cycle out of reset, plus scoreboard on listo rise.
    logic       listo_prev = 1'b0;
    logic [7:0] sb_e;
    always @(negedge clock) begin
        if (!reset) begin
            chk("estado", {5'd0, estado}, 8'(m_state));
            chk("listo", {7'd0, listo}, {7'd0, m_listo});
            chk("op_a", {4'd0, op_a}, {4'd0, m_a});
            chk("op_b", {4'd0, op_b}, {4'd0, m_b});
            chk("sel", {5'd0, sel}, {5'd0, m_sel});
            chk("resultado", {4'd0, resultado}, {4'd0, m_res});
            chk("banderas", {4'd0, banderas}, {4'd0, m_ban});
            if (listo && !listo_prev) begin
                chk("sb_nonempty", {7'd0, exp_q.size() != 0}, 8'd1);
                if (exp_q.size() != 0) begin
                    sb_e = exp_q.pop_front();
                    chk("sb_result", {resultado, banderas}, sb_e);
                end
            end
        end
        listo_prev = reset ? 1'b0 : listo;
    end

    // Driver: one button press with dato_in presented, then release.
    task automatic step(input logic [3:0] v);
        dato_in = v;
        boton   = 1'b1;
        repeat (4) @(negedge clock);
        boton   = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic cancel_pulse();
        cancelar = 1'b1;
        @(negedge clock);
        cancelar = 1'b0;
        @(negedge clock);
    endtask

    logic [3:0] e_res;
    logic [3:0] e_ban;
    logic [2:0] e_sel;

    initial begin
        reset = 1'b1; boton = 1'b0; cancelar = 1'b0; dato_in = '0;
        repeat (3) @(negedge clock);
        chk("rst_estado", {5'd0, estado}, 8'd0);
        chk("rst_listo", {7'd0, listo}, 8'd0);
        reset = 1'b0;
        @(negedge clock);

        // Load A=5, then reset asynchronously mid-CARGA_B.
        step(4'd5);
        chk("lit_op_a_5", {4'd0, op_a}, 8'd5);
        chk("lit_estado_1", {5'd0, estado}, 8'd1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_op_a", {4'd0, op_a}, 8'd0);
        chk("arst_op_b", {4'd0, op_b}, 8'd0);
        chk("arst_sel", {5'd0, sel}, 8'd0);
        chk("arst_res", {4'd0, resultado}, 8'd0);
        chk("arst_ban", {4'd0, banderas}, 8'd0);
        chk("arst_estado", {5'd0, estado}, 8'd0);
        chk("arst_listo", {7'd0, listo}, 8'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // First step after reset loads A; then cancel back to CARGA_A.
        step(4'd6);
        chk("lit_op_a_6", {4'd0, op_a}, 8'd6);
        cancel_pulse();
        chk("lit_cancel_estado", {5'd0, estado}, 8'd0);

        // Full sequence 3 + 4 with sel=0.
        step(4'd3);
        step(4'd4);
        step(4'd0);
        chk("lit_res_7", {4'd0, resultado}, 8'd7);
        chk("lit_ban_0", {4'd0, banderas}, 8'd0);
        chk("lit_listo_1", {7'd0, listo}, 8'd1);
        chk("lit_estado_4", {5'd0, estado}, 8'd4);

        // Step out of MUESTRA: chaining or plain return.
        step(4'd1);
`ifdef ALU_SECUENCIADOR_ACUM_EN
        chk("lit_chain_op_a", {4'd0, op_a}, 8'd7);
        chk("lit_chain_estado", {5'd0, estado}, 8'd1);
        step(4'd2);
        step(4'd0);
        e_res = 4'h9; e_ban = 4'b1001; e_sel = 3'd0;
`else
        chk("lit_noacc_op_a", {4'd0, op_a}, 8'd3);
        chk("lit_noacc_estado", {5'd0, estado}, 8'd0);
        step(4'd2);
        step(4'd5);
        step(4'd1);
        e_res = 4'hD; e_ban = 4'b1010; e_sel = 3'd1;
`endif
        chk("lit_res_2nd", {4'd0, resultado}, {4'd0, e_res});
        chk("lit_ban_2nd", {4'd0, banderas}, {4'd0, e_ban});

        // Cancel from MUESTRA: listo drops, result held.
        cancel_pulse();
        chk("lit_cancel_listo", {7'd0, listo}, 8'd0);
        chk("lit_cancel_res_hold", {4'd0, resultado}, {4'd0, e_res});

        // Held button: exactly one advance.
        dato_in = 4'd9;
        boton   = 1'b1;
        repeat (50) @(negedge clock);
        boton   = 1'b0;
        repeat (4) @(negedge clock);
        chk("lit_held_op_a", {4'd0, op_a}, 8'd9);
        chk("lit_held_estado", {5'd0, estado}, 8'd1);

        // Cancel coinciding with the opcode pulse.
        step(4'd8);
        dato_in = 4'd2;
        boton   = 1'b1;
        repeat (2) @(negedge clock);
        cancelar = 1'b1;
        @(negedge clock);
        cancelar = 1'b0;
        repeat (3) @(negedge clock);
        boton = 1'b0;
        repeat (4) @(negedge clock);
        chk("lit_prio_estado", {5'd0, estado}, 8'd0);
        chk("lit_prio_sel", {5'd0, sel}, {5'd0, e_sel});
        chk("lit_prio_listo", {7'd0, listo}, 8'd0);

        // Fastest tap pair after the opcode step. Pulses are at least two edges
        // apart, so the follow-up lands on the first MUESTRA edge, not EJECUTA.
        step(4'd1);
        step(4'd2);
        dato_in = 4'd0;
        boton = 1'b1; @(negedge clock);
        boton = 1'b0; @(negedge clock);
        boton = 1'b1; @(negedge clock);
        boton = 1'b0;
        repeat (6) @(negedge clock);
        chk("lit_tap_res", {4'd0, resultado}, 8'd3);
        chk("lit_tap_listo", {7'd0, listo}, 8'd0);
`ifdef ALU_SECUENCIADOR_ACUM_EN
        chk("lit_tap_estado", {5'd0, estado}, 8'd1);
        chk("lit_tap_op_a", {4'd0, op_a}, 8'd3);
`else
        chk("lit_tap_estado", {5'd0, estado}, 8'd0);
`endif

        chk("sb_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
